reg_file_mp: RTL and testbench

- Parametrised multi-read-port register file for the pipelined datapath; successor to the fixed 32x32, 2-read-port register file.
- Adds the following over the fixed block:
  - configurable width, depth and read-port count;
  - asynchronous clear on reset;
  - write-to-read bypass;
  - hardwired-zero register 0;
  - a per-register pending-write scoreboard for hazard detection;
  - a sequenced bulk-clear command.
- Sits between decode (reads, issue) and writeback (write port).

---
 rtl/reg_file_mp_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/reg_file_mp.sv | 121 ++++++++++++
 tb/tb_reg_file_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizes for the multi-read-port register file.
package reg_file_mp_pkg;

    localparam int unsigned RfWidth = 32;
    localparam int unsigned RfDepth = 32;
    localparam int unsigned RfNumRd = 2;

    typedef enum logic {
        StIdle,
        StClear
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on
// writeback or by the bulk-clear sweep, with one lookup per read port.
module rf_scoreboard #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_vld,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_vld,
    input  logic [AW-1:0]     clr_addr,
    input  logic              sweep_vld,
    input  logic [AW-1:0]     sweep_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (sweep_vld) begin
            busy_d[sweep_addr] = 1'b0;
        end else begin
            // Set after clear so a new producer supersedes a same-cycle writeback.
            if (clr_vld) busy_d[clr_addr] = 1'b0;
            if (set_vld) busy_d[set_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = busy_q[raddr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NRD combinational read ports, one write port with
// optional bypass, hardwired r0, pending-write scoreboard and a bulk-clear sweep.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned W       = RfWidth,
    parameter int unsigned DEPTH   = RfDepth,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned NRD     = RfNumRd,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [W-1:0]      wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*W-1:0]  rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              issue_vld,
    input  logic [AW-1:0]     issue_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [AW:0] CntLast = (AW+1)'(DEPTH - 1);

    logic [W-1:0]   mem_q [DEPTH];
    rf_state_e      state_q, state_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           idle;
    logic           wr_en;
    logic [NRD-1:0] sb_busy;
    logic [AW-1:0]  ra;

    assign idle  = (state_q == StIdle);
    assign wr_en = we && idle && !(ZERO_R0 != 0 && waddr == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_busy = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    clr_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (!idle) begin
            mem_q[cnt_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .NRD     (NRD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_vld    (issue_vld && idle),
        .set_addr   (issue_addr),
        .clr_vld    (we && idle),
        .clr_addr   (waddr),
        .sweep_vld  (!idle),
        .sweep_addr (cnt_q[AW-1:0]),
        .raddr      (raddr),
        .rbusy      (sb_busy)
    );

    // During a sweep every port reads 0 and not-busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            if (idle) begin
                if (BYPASS != 0 && wr_en && waddr == ra) begin
                    rdata[i*W +: W] = wdata;
                end else begin
                    if (!(ZERO_R0 != 0 && ra == '0)) rdata[i*W +: W] = mem_q[ra];
                    rbusy[i] = sb_busy[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: two instances (bypass+zero-r0, and neither)
// driven in lockstep and compared each cycle against an array-based reference.
module tb_reg_file_mp;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we = 1'b0;
    logic [AW-1:0]     waddr = '0;
    logic [W-1:0]      wdata = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic              issue_vld = 1'b0;
    logic [AW-1:0]     issue_addr = '0;
    logic              clr_req = 1'b0;
    logic [NRD*W-1:0]  rdata0, rdata1;
    logic [NRD-1:0]    rbusy0, rbusy1;
    logic              cb0, cb1, cd0, cd1;

    always #5 clk = ~clk;

    reg_file_mp #(.W(W), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1), .ZERO_R0(1)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata0), .rbusy(rbusy0), .issue_vld(issue_vld), .issue_addr(issue_addr),
        .clr_req(clr_req), .clr_busy(cb0), .clr_done(cd0)
    );

    reg_file_mp #(.W(W), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(0), .ZERO_R0(0)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata1), .rbusy(rbusy1), .issue_vld(issue_vld), .issue_addr(issue_addr),
        .clr_req(clr_req), .clr_busy(cb1), .clr_done(cd1)
    );

    // Reference: register contents and pending flags per instance, plus cycles left in a sweep.
    logic [W-1:0] m_mem  [2][DEPTH];
    bit           m_busy [2][DEPTH];
    int           sweep_left = 0;
    int           busy_cycles = 0;
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
        sweep_left = 0;
    endtask

    task automatic check_outputs();
        logic [NRD*W-1:0] rd;
        logic [NRD-1:0]   rb;
        logic             cb, cd, zr, byp, wr;
        logic [AW-1:0]    ra;
        logic [W-1:0]     exp_d;
        logic             exp_b;
        for (int k = 0; k < 2; k++) begin
            zr  = (k == 0);
            byp = (k == 0);
            rd  = (k == 0) ? rdata0 : rdata1;
            rb  = (k == 0) ? rbusy0 : rbusy1;
            cb  = (k == 0) ? cb0 : cb1;
            cd  = (k == 0) ? cd0 : cd1;
            check($sformatf("i%0d clr_busy", k), 64'(cb), 64'(sweep_left > 0));
            check($sformatf("i%0d clr_done", k), 64'(cd), 64'(sweep_left == 1));
            for (int p = 0; p < NRD; p++) begin
                ra = raddr[p*AW +: AW];
                wr = we && !(zr && waddr == 0);
                if (sweep_left > 0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end else if (byp && wr && waddr == ra) begin
                    exp_d = wdata;
                    exp_b = 1'b0;
                end else begin
                    exp_d = (zr && ra == 0) ? '0 : m_mem[k][ra];
                    exp_b = m_busy[k][ra];
                end
                check($sformatf("i%0d rdata%0d r%0d", k, p, ra), 64'(rd[p*W +: W]), 64'(exp_d));
                check($sformatf("i%0d rbusy%0d r%0d", k, p, ra), 64'(rb[p]), 64'(exp_b));
            end
        end
        if (cb0) busy_cycles++;
    endtask

    task automatic model_edge();
        logic zr;
        if (sweep_left > 0) begin
            for (int k = 0; k < 2; k++) begin
                m_mem[k][DEPTH - sweep_left]  = '0;
                m_busy[k][DEPTH - sweep_left] = 1'b0;
            end
            sweep_left--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                zr = (k == 0);
                if (we && !(zr && waddr == 0)) begin
                    m_mem[k][waddr]  = wdata;
                    m_busy[k][waddr] = 1'b0;
                end
                if (we && !zr && waddr == 0) m_busy[k][0] = 1'b0;
                if (issue_vld && !(zr && issue_addr == 0)) m_busy[k][issue_addr] = 1'b1;
            end
            if (clr_req) sweep_left = DEPTH;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic iv, input logic [AW-1:0] ia, input logic cr);
        we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
        issue_vld = iv; issue_addr = ia; clr_req = cr;
        step();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a += 2)
            drive(1'b0, '0, '0, AW'(a), AW'(a + 1), 1'b0, '0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check("reset clr_busy", 64'(cb0), 64'(0));
        check("reset clr_done", 64'(cd0), 64'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Reset state and first write / read-back.
        drive(1'b0, '0, '0, 5'd3, 5'd5, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd3, 32'h1234_5678, 5'd5, 5'd3, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 5'd5, 5'd3, 1'b0, '0, 1'b0);
        check("r3 readback", 64'(rdata0[W +: W]), 64'(32'h1234_5678));

        // Same-cycle bypass.
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr = {5'd0, 5'd7};
        #1;
        check("bypass on", 64'(rdata0[W-1:0]), 64'(32'hDEAD_BEEF));
        check("bypass off", 64'(rdata1[W-1:0]), 64'(0));
        step();

        // r0 writes and issues.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd1, 5'd1, 1'b1, 5'd0, 1'b0);
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b0, '0, 1'b0);

        // Scoreboard set / clear / set-wins.
        drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd9, 32'h99, 5'd1, 5'd2, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd9, 32'h98, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0);
        drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b0, '0, 1'b0);
        check("set wins", 64'(rbusy0), 64'(2'b11));

        // Bulk clear with a dropped write mid-sweep.
        for (int a = 1; a < DEPTH; a++)
            drive(1'b1, AW'(a), W'(a) * 32'h0101_0101 + 32'd1, 5'd0, 5'd0, 1'b1, AW'(a), 1'b0);
        busy_cycles = 0;
        drive(1'b0, '0, '0, 5'd4, 5'd31, 1'b0, '0, 1'b1);
        for (int c = 0; c < DEPTH + 2; c++)
            drive(c == 5, 5'd4, 32'hBAD0_0004, 5'd4, AW'(c), c == 6, 5'd6, c == 7);
        check("clear length", 64'(busy_cycles), 64'(DEPTH));
        read_all();

        // Reset in the middle of a sweep.
        for (int a = 1; a < 8; a++)
            drive(1'b1, AW'(a), 32'hA5A5_0000 | W'(a), 5'd0, 5'd0, 1'b1, AW'(a), 1'b0);
        drive(1'b0, '0, '0, 5'd1, 5'd2, 1'b0, '0, 1'b1);
        for (int c = 0; c < 10; c++) drive(1'b0, '0, '0, 5'd1, 5'd2, 1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        check("midclr clr_busy0", 64'(cb0), 64'(0));
        check("midclr clr_busy1", 64'(cb1), 64'(0));
        check("midclr clr_done0", 64'(cd0), 64'(0));
        check("midclr clr_done1", 64'(cd1), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        read_all();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [AW-1:0] wa, r0, r1;
            wa = AW'($urandom);
            r0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            drive(logic'($urandom_range(0, 1)), wa, $urandom, r0, r1,
                  $urandom_range(0, 9) < 4, AW'($urandom), $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
